uart_rx_engine: RTL and testbench

//  Parametrised UART receiver: configurable data width, parity and stop bits, internal baud timing.

---
 rtl/uart_rx_engine.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   UART receiver with configurable data width, parity and stop bits and
//   internal baud timing. It feeds a speculative FWFT FIFO. Each word is
//   written when its last data bit lands, then committed or rolled back once
//   the parity and stop checks resolve.
//
// Ports
//   CLK288MHZ     : sole clock
//   resetN        : asynchronous active-low reset
//   uart_rxd_out  : asynchronous serial line, idles high
//   dataOut       : received word, LSB = first bit on the wire
//   writeEn       : 1-cycle speculative FIFO write strobe
//   commitWrite   : 1-cycle pulse, pending word becomes visible
//   rollbackWrite : 1-cycle pulse, pending word is discarded
//   parityErr     : 1-cycle pulse alongside rollbackWrite
//   frameErr      : 1-cycle pulse alongside rollbackWrite
//   breakDet      : 1-cycle pulse on a break frame
//   busy          : high whenever the receiver is not idle
module uart_rx_engine #(
    parameter int CLK_PER_BIT  = 48,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int SAMPLE_POINT = 24
) (
    input  logic                 CLK288MHZ,
    input  logic                 resetN,
    input  logic                 uart_rxd_out,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 writeEn,
    output logic                 commitWrite,
    output logic                 rollbackWrite,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 breakDet,
    output logic                 busy
);

    localparam int PH_W  = 12;
    localparam int CNT_W = 4;
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_PER_BIT - 1);
    localparam logic [PH_W-1:0]  PH_VOTE   = PH_W'(SAMPLE_POINT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t               state;
    logic                 sync_p0, sync_p1;
    logic [2:0]           taps_p2;
    logic [PH_W-1:0]      phase;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 all_zero, stop_bad, par_err;

    function automatic logic majority3(input logic [2:0] t);
        return (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
    endfunction

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_MODE == 2) ? ~(^d) : (^d);
    endfunction

    logic                 vote, sample_now, line_fall, stop_final_bad;
    logic [DATA_BITS-1:0] shreg_next;

    // taps_p2 holds the line at phases SAMPLE_POINT-1..SAMPLE_POINT+1 when
    // the phase counter reads SAMPLE_POINT+1.
    assign vote           = majority3(taps_p2);
    assign sample_now     = (phase == PH_VOTE);
    assign line_fall      = ~sync_p1 & taps_p2[0];
    assign shreg_next     = {vote, shreg[DATA_BITS-1:1]};
    assign stop_final_bad = stop_bad | ~vote;
    assign busy           = (state != IDLE);

    // Stage p0/p1: synchroniser, p2: vote taps. Reset to the idle level so
    // that leaving reset never looks like a start edge.
    always_ff @(posedge CLK288MHZ or negedge resetN) begin
        if (!resetN) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            taps_p2 <= 3'b111;
        end else begin
            sync_p0 <= uart_rxd_out;
            sync_p1 <= sync_p0;
            taps_p2 <= {taps_p2[1:0], sync_p1};
        end
    end

    always_ff @(posedge CLK288MHZ) begin
        if (state == DATA && sample_now) shreg <= shreg_next;
    end

    always_ff @(posedge CLK288MHZ or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            phase         <= '0;
            bit_cnt       <= '0;
            all_zero      <= 1'b0;
            stop_bad      <= 1'b0;
            par_err       <= 1'b0;
            dataOut       <= '0;
            writeEn       <= 1'b0;
            commitWrite   <= 1'b0;
            rollbackWrite <= 1'b0;
            parityErr     <= 1'b0;
            frameErr      <= 1'b0;
            breakDet      <= 1'b0;
        end else begin
            writeEn       <= 1'b0;
            commitWrite   <= 1'b0;
            rollbackWrite <= 1'b0;
            parityErr     <= 1'b0;
            frameErr      <= 1'b0;
            breakDet      <= 1'b0;
            if (state != IDLE) phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (line_fall) state <= START;
                end
                START: if (sample_now) begin
                    if (vote) begin
                        state <= IDLE;
                    end else begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        all_zero <= 1'b1;
                        stop_bad <= 1'b0;
                        par_err  <= 1'b0;
                    end
                end
                DATA: if (sample_now) begin
                    all_zero <= all_zero & ~vote;
                    if (bit_cnt == DATA_LAST) begin
                        dataOut <= shreg_next;
                        writeEn <= 1'b1;
                        bit_cnt <= '0;
                        state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                PARITY: if (sample_now) begin
                    all_zero <= all_zero & ~vote;
                    if (vote != parity_of(shreg)) par_err <= 1'b1;
                    state <= STOP;
                end
                STOP: if (sample_now) begin
                    if (bit_cnt == STOP_LAST) begin
                        // Returning to IDLE here, mid stop bit, lets a
                        // back-to-back start edge be caught.
                        if (all_zero & ~vote) begin
                            rollbackWrite <= 1'b1;
                            breakDet      <= 1'b1;
                            frameErr      <= 1'b1;
                            phase         <= '0;
                            state         <= BREAK;
                        end else begin
                            commitWrite   <= ~(stop_final_bad | par_err);
                            rollbackWrite <= stop_final_bad | par_err;
                            frameErr      <= stop_final_bad;
                            parityErr     <= par_err;
                            state         <= IDLE;
                        end
                    end else begin
                        stop_bad <= stop_final_bad;
                        all_zero <= all_zero & ~vote;
                        bit_cnt  <= bit_cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    // phase counts consecutive high cycles of the line
                    if (!sync_p1) begin
                        phase <= '0;
                    end else if (phase == PH_LAST) begin
                        phase <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
module tb_uart_rx_engine;

    localparam int CPB  = 48;
    localparam int SP   = 24;
    localparam int LAT  = SP + 5;
    localparam int NDUT = 4;
    // configurations: 0 = 8N1, 1 = 8E1, 2 = 8N2, 3 = 9O1
    localparam int DB [NDUT] = '{8, 8, 8, 9};
    localparam int PM [NDUT] = '{0, 1, 0, 2};
    localparam int SB [NDUT] = '{1, 1, 2, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NDUT-1:0] line = '1;
    logic [NDUT-1:0] we, cm, rb, pe, fe, bd, bz;
    logic [NDUT-1:0][8:0] dout;
    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [DB[g]-1:0] d;
        uart_rx_engine #(
            .CLK_PER_BIT(CPB), .DATA_BITS(DB[g]), .PARITY_MODE(PM[g]),
            .STOP_BITS(SB[g]), .SAMPLE_POINT(SP)
        ) u_dut (
            .CLK288MHZ(clk), .resetN(rst_n), .uart_rxd_out(line[g]),
            .dataOut(d), .writeEn(we[g]), .commitWrite(cm[g]),
            .rollbackWrite(rb[g]), .parityErr(pe[g]), .frameErr(fe[g]),
            .breakDet(bd[g]), .busy(bz[g])
        );
        assign dout[g] = 9'(d);
    end

    // Event log: every write strobe and every resolution, with cycle stamps.
    int         wcnt [NDUT];
    int         rcnt [NDUT];
    int         stray[NDUT];
    logic [8:0] wdata[NDUT][16];
    int         wcyc [NDUT][16];
    logic [4:0] rkind[NDUT][16];   // {breakDet, frameErr, parityErr, rollback, commit}
    int         rcyc [NDUT][16];

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            wcnt[g] = 0; rcnt[g] = 0; stray[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (we[g]) begin
                wdata[g][wcnt[g] % 16] <= dout[g];
                wcyc[g][wcnt[g] % 16]  <= cyc;
                wcnt[g] <= wcnt[g] + 1;
            end
            if (cm[g] | rb[g]) begin
                rkind[g][rcnt[g] % 16] <= {bd[g], fe[g], pe[g], rb[g], cm[g]};
                rcyc[g][rcnt[g] % 16]  <= cyc;
                rcnt[g] <= rcnt[g] + 1;
            end else if (pe[g] | fe[g] | bd[g]) begin
                stray[g] <= stray[g] + 1;
            end
        end
    end

    // Reference model: expected resolution of a frame from its wire contents.
    function automatic logic [8:0] mask_of(input int i);
        return 9'((1 << DB[i]) - 1);
    endfunction

    function automatic logic good_par(input int i, input logic [8:0] data);
        int ones;
        ones = $countones(data & mask_of(i));
        return (PM[i] == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
    endfunction

    function automatic logic [4:0] model(input int i, input logic [8:0] data,
                                         input logic pbit, input logic [1:0] stops);
        int   ones;
        logic par_ok, sbad, brk;
        ones   = $countones(data & mask_of(i)) + ((PM[i] != 0) ? int'(pbit) : 0);
        par_ok = (PM[i] == 0) || ((PM[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1));
        sbad   = (stops[0] == 1'b0) || (SB[i] == 2 && stops[1] == 1'b0);
        brk    = ((data & mask_of(i)) == 9'd0) && (PM[i] == 0 || pbit == 1'b0) &&
                 (stops[0] == 1'b0) && (SB[i] == 1 || stops[1] == 1'b0);
        if (brk) return 5'b11010;
        return {1'b0, sbad, !par_ok, sbad | !par_ok, !(sbad | !par_ok)};
    endfunction

    // Stimulus helpers (no checking inside)
    task automatic drive_bit(input int i, input logic b, output int lead);
        @(posedge clk);
        #1;
        line[i] = b;
        lead = cyc;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input int i, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, output int dlead, output int slead);
        int l;
        dlead = 0;
        slead = 0;
        drive_bit(i, 1'b0, l);
        for (int b = 0; b < DB[i]; b++) begin
            drive_bit(i, data[b], l);
            dlead = l;
        end
        if (PM[i] != 0) drive_bit(i, pbit, l);
        for (int s = 0; s < SB[i]; s++) begin
            drive_bit(i, stops[s], l);
            slead = l;
        end
    endtask

    task automatic idle(input int i, input int n);
        @(posedge clk);
        #1;
        line[i] = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            nvec++;
            if ({we[i], cm[i], rb[i], pe[i], fe[i], bd[i], bz[i]} !== 7'd0) begin
                nerr++;
                $display("FAIL reset_strobes dut%0d: got %b want 0000000", i,
                         {we[i], cm[i], rb[i], pe[i], fe[i], bd[i], bz[i]});
            end
            nvec++;
            if (dout[i] !== 9'd0) begin
                nerr++;
                $display("FAIL reset_dataOut dut%0d: got %h want 000", i, dout[i]);
            end
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic_8n1();
        int w0, r0, dl, sl;
        w0 = wcnt[0]; r0 = rcnt[0];
        send_frame(0, 9'h0A5, 1'b0, 2'b11, dl, sl);
        idle(0, CPB);
        nvec++;
        if (wcnt[0] - w0 !== 1) begin nerr++; $display("FAIL basic_wcount: got %0d want 1", wcnt[0] - w0); end
        nvec++;
        if (wdata[0][w0 % 16] !== 9'h0A5) begin nerr++; $display("FAIL basic_data: got %h want 0a5", wdata[0][w0 % 16]); end
        nvec++;
        if (wcyc[0][w0 % 16] - dl !== LAT) begin nerr++; $display("FAIL basic_we_latency: got %0d want %0d", wcyc[0][w0 % 16] - dl, LAT); end
        nvec++;
        if (rcnt[0] - r0 !== 1) begin nerr++; $display("FAIL basic_rcount: got %0d want 1", rcnt[0] - r0); end
        nvec++;
        if (rkind[0][r0 % 16] !== 5'b00001) begin nerr++; $display("FAIL basic_kind: got %b want 00001", rkind[0][r0 % 16]); end
        nvec++;
        if (rcyc[0][r0 % 16] - sl !== LAT) begin nerr++; $display("FAIL basic_commit_latency: got %0d want %0d", rcyc[0][r0 % 16] - sl, LAT); end
    endtask

    task automatic test_parity_8e1();
        int w0, r0, dl, sl;
        w0 = wcnt[1]; r0 = rcnt[1];
        send_frame(1, 9'h03C, 1'b1, 2'b11, dl, sl);
        idle(1, CPB);
        nvec++;
        if (wcnt[1] - w0 !== 1 || wdata[1][w0 % 16] !== 9'h03C) begin
            nerr++; $display("FAIL parity_write: got n=%0d data=%h want n=1 data=03c", wcnt[1] - w0, wdata[1][w0 % 16]);
        end
        nvec++;
        if (rcnt[1] - r0 !== 1 || rkind[1][r0 % 16] !== 5'b00110) begin
            nerr++; $display("FAIL parity_kind: got n=%0d kind=%b want n=1 kind=00110", rcnt[1] - r0, rkind[1][r0 % 16]);
        end
    endtask

    task automatic test_stop_8n2();
        int w0, r0, dl, sl;
        w0 = wcnt[2]; r0 = rcnt[2];
        send_frame(2, 9'h096, 1'b0, 2'b01, dl, sl);
        idle(2, CPB);
        send_frame(2, 9'h05A, 1'b0, 2'b11, dl, sl);
        idle(2, CPB);
        nvec++;
        if (wcnt[2] - w0 !== 2) begin nerr++; $display("FAIL stop_wcount: got %0d want 2", wcnt[2] - w0); end
        nvec++;
        if (rkind[2][r0 % 16] !== 5'b01010) begin nerr++; $display("FAIL stop_frame_err: got %b want 01010", rkind[2][r0 % 16]); end
        nvec++;
        if (wdata[2][(w0 + 1) % 16] !== 9'h05A || rkind[2][(r0 + 1) % 16] !== 5'b00001) begin
            nerr++; $display("FAIL stop_next_commit: got data=%h kind=%b want data=05a kind=00001",
                             wdata[2][(w0 + 1) % 16], rkind[2][(r0 + 1) % 16]);
        end
        nvec++;
        if (rcyc[2][(r0 + 1) % 16] - sl !== LAT) begin nerr++; $display("FAIL stop_commit_latency: got %0d want %0d", rcyc[2][(r0 + 1) % 16] - sl, LAT); end
    endtask

    task automatic test_false_start();
        int w0, r0;
        w0 = wcnt[0]; r0 = rcnt[0];
        @(posedge clk);
        #1;
        line[0] = 1'b0;
        for (int c = 1; c <= SP + 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 15) line[0] = 1'b1;
            if (c == 8) begin
                nvec++;
                if (bz[0] !== 1'b1) begin nerr++; $display("FAIL glitch_busy_high: got %b want 1", bz[0]); end
            end
        end
        nvec++;
        if (bz[0] !== 1'b0) begin nerr++; $display("FAIL glitch_busy_low: got %b want 0", bz[0]); end
        idle(0, CPB);
        nvec++;
        if (wcnt[0] !== w0 || rcnt[0] !== r0) begin
            nerr++; $display("FAIL glitch_no_strobe: got w=%0d r=%0d want w=%0d r=%0d", wcnt[0], rcnt[0], w0, r0);
        end
    endtask

    task automatic test_break();
        int w0, r0, l, sl, dl;
        w0 = wcnt[0]; r0 = rcnt[0];
        sl = 0;
        for (int b = 0; b < 12; b++) begin
            drive_bit(0, 1'b0, l);
            if (b == 9) sl = l;
        end
        nvec++;
        if (wcnt[0] - w0 !== 1 || wdata[0][w0 % 16] !== 9'h000) begin
            nerr++; $display("FAIL break_write: got n=%0d data=%h want n=1 data=000", wcnt[0] - w0, wdata[0][w0 % 16]);
        end
        nvec++;
        if (rcnt[0] - r0 !== 1 || rkind[0][r0 % 16] !== model(0, 9'h000, 1'b0, 2'b00)) begin
            nerr++; $display("FAIL break_kind: got n=%0d kind=%b want n=1 kind=%b", rcnt[0] - r0, rkind[0][r0 % 16], model(0, 9'h000, 1'b0, 2'b00));
        end
        nvec++;
        if (rcyc[0][r0 % 16] - sl !== LAT) begin nerr++; $display("FAIL break_latency: got %0d want %0d", rcyc[0][r0 % 16] - sl, LAT); end
        @(posedge clk);
        #1;
        line[0] = 1'b1;
        for (int c = 1; c <= CPB + 8; c++) begin
            @(posedge clk);
            #1;
            if (c == CPB / 2) begin
                nvec++;
                if (bz[0] !== 1'b1) begin nerr++; $display("FAIL break_hold: got busy=%b want 1", bz[0]); end
            end
        end
        nvec++;
        if (bz[0] !== 1'b0) begin nerr++; $display("FAIL break_release: got busy=%b want 0", bz[0]); end
        send_frame(0, 9'h081, 1'b0, 2'b11, dl, sl);
        idle(0, CPB);
        nvec++;
        if (wdata[0][(w0 + 1) % 16] !== 9'h081 || rkind[0][(r0 + 1) % 16] !== 5'b00001) begin
            nerr++; $display("FAIL break_after_frame: got data=%h kind=%b want data=081 kind=00001",
                             wdata[0][(w0 + 1) % 16], rkind[0][(r0 + 1) % 16]);
        end
    endtask

    task automatic test_random();
        int         w0, r0, dl, sl;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        for (int i = 0; i < NDUT; i++) begin
            for (int n = 0; n < 6; n++) begin
                w0 = wcnt[i]; r0 = rcnt[i];
                data  = 9'($urandom) & mask_of(i);
                pbit  = good_par(i, data) ^ ($urandom_range(0, 3) == 0);
                stops = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
                send_frame(i, data, pbit, stops, dl, sl);
                idle(i, 2 * CPB);
                nvec++;
                if (wcnt[i] - w0 !== 1 || wdata[i][w0 % 16] !== data) begin
                    nerr++; $display("FAIL rand_write dut%0d: got n=%0d data=%h want n=1 data=%h", i, wcnt[i] - w0, wdata[i][w0 % 16], data);
                end
                nvec++;
                if (rcnt[i] - r0 !== 1 || rkind[i][r0 % 16] !== model(i, data, pbit, stops)) begin
                    nerr++; $display("FAIL rand_kind dut%0d data=%h p=%b s=%b: got n=%0d kind=%b want n=1 kind=%b",
                                     i, data, pbit, stops, rcnt[i] - r0, rkind[i][r0 % 16], model(i, data, pbit, stops));
                end
                nvec++;
                if (rcyc[i][r0 % 16] - sl !== LAT) begin
                    nerr++; $display("FAIL rand_latency dut%0d: got %0d want %0d", i, rcyc[i][r0 % 16] - sl, LAT);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0, r0, dl, sl, l;
        w0 = wcnt[3]; r0 = rcnt[3];
        send_frame(3, 9'h1FF, good_par(3, 9'h1FF), 2'b11, dl, sl);
        send_frame(3, 9'h000, good_par(3, 9'h000), 2'b11, dl, sl);
        idle(3, CPB);
        nvec++;
        if (wcnt[3] - w0 !== 2 || rcnt[3] - r0 !== 2) begin
            nerr++; $display("FAIL b2b_counts: got w=%0d r=%0d want w=2 r=2", wcnt[3] - w0, rcnt[3] - r0);
        end
        nvec++;
        if (wdata[3][w0 % 16] !== 9'h1FF || wdata[3][(w0 + 1) % 16] !== 9'h000) begin
            nerr++; $display("FAIL b2b_order: got %h,%h want 1ff,000", wdata[3][w0 % 16], wdata[3][(w0 + 1) % 16]);
        end
        nvec++;
        if (rkind[3][r0 % 16] !== 5'b00001 || rkind[3][(r0 + 1) % 16] !== 5'b00001) begin
            nerr++; $display("FAIL b2b_commit: got %b,%b want 00001,00001", rkind[3][r0 % 16], rkind[3][(r0 + 1) % 16]);
        end
        // third frame interrupted by reset during its data bits
        w0 = wcnt[3]; r0 = rcnt[3];
        drive_bit(3, 1'b0, l);
        drive_bit(3, 1'b1, l);
        drive_bit(3, 1'b0, l);
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({we[3], cm[3], rb[3], pe[3], fe[3], bd[3], bz[3]} !== 7'd0 || dout[3] !== 9'd0) begin
            nerr++; $display("FAIL midreset_outputs: got %b data=%h want 0000000 data=000",
                             {we[3], cm[3], rb[3], pe[3], fe[3], bd[3], bz[3]}, dout[3]);
        end
        line[3] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        nvec++;
        if (wcnt[3] !== w0 || rcnt[3] !== r0) begin
            nerr++; $display("FAIL midreset_no_commit: got w=%0d r=%0d want w=%0d r=%0d", wcnt[3], rcnt[3], w0, r0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity_8e1();
        test_stop_8n2();
        test_false_start();
        test_break();
        test_random();
        test_back_to_back();
        for (int i = 0; i < NDUT; i++) begin
            nvec++;
            if (stray[i] !== 0 || wcnt[i] !== rcnt[i]) begin
                nerr++; $display("FAIL pairing dut%0d: got stray=%0d w=%0d r=%0d want stray=0 w=r", i, stray[i], wcnt[i], rcnt[i]);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
